egd_bitstream_ctrl: RTL and testbench

// Sequencer and bit-window manager in front of the Exp-Golomb decoder core. Upstream 16-bit

---
 rtl/egd_pkg.sv | 32 +++
 rtl/egd_bit_window.sv | 70 +++++++
 rtl/egd_bitstream_ctrl.sv | 153 +++++++++++++++
 tb/tb_egd_bitstream_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/egd_pkg.sv
// Shared types and constants for the Exp-Golomb bitstream controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package egd_pkg;

    localparam int WORD_W = 16;            // bitstream word width
    localparam int VAL_W  = 8;             // decoded value width
    localparam int LEN_W  = 5;             // codeword length width
    localparam int WIN_W  = 2 * WORD_W;    // window holds two words
    localparam int CNT_W  = 6;             // window fill count, 0..32

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        DECODE = 3'd2,
        OUTPUT = 3'd3,
        ERR    = 3'd4
    } state_t;

    // Decode-select codes; carried through to the decoder, never interpreted here
    localparam logic [1:0] SEL_UE  = 2'd0;
    localparam logic [1:0] SEL_SE  = 2'd1;
    localparam logic [1:0] SEL_TE  = 2'd2;
    localparam logic [1:0] SEL_FIX = 2'd3;

    // A codeword must consume at least one bit and no more than the decoder sees
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(WORD_W));
    endfunction

endpackage

// File: rtl/egd_bit_window.sv
// Left-aligned 32-bit bit window: consume shift from the top, word append below the valid bits.
// Latency: one cycle from consume/append to updated window and count.
// Backpressure: bs_ready drops once more than one word is buffered, in ERR, or during a flush.
module egd_bit_window
    import egd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,        // synchronous flush
    input  logic              i_consume,    // drop i_len bits from the top this cycle
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_hold,       // sequencer in ERR: refuse words
    input  logic              i_bs_valid,
    input  logic [WORD_W-1:0] i_bs_word,
    output logic              o_bs_ready,
    output logic [WORD_W-1:0] o_window,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [WIN_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIN_W-1:0] w_buf_shift;
    logic [CNT_W-1:0] w_cnt_shift;
    logic [WIN_W-1:0] w_word_aligned;
    logic [WIN_W-1:0] w_buf_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_append;

    // Consume first, then place the incoming word right below the surviving bits
    always_comb begin
        w_buf_shift    = r_buf;
        w_cnt_shift    = r_cnt;
        if (i_consume) begin
            w_buf_shift = r_buf << i_len;
            w_cnt_shift = r_cnt - CNT_W'(i_len);
        end
        o_bs_ready     = (r_cnt <= CNT_W'(WORD_W)) && !i_hold && !i_clr;
        w_append       = i_bs_valid && o_bs_ready;
        // Bits below the valid count are zero, so OR-ing the aligned word is exact
        w_word_aligned = {i_bs_word, {WORD_W{1'b0}}} >> w_cnt_shift;
        w_buf_next     = w_buf_shift;
        w_cnt_next     = w_cnt_shift;
        if (w_append) begin
            w_buf_next = w_buf_shift | w_word_aligned;
            w_cnt_next = w_cnt_shift + CNT_W'(WORD_W);
        end
    end

    // Window and count registers; flush wins over any same-cycle activity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign o_window = r_buf[WIN_W-1 -: WORD_W];
    assign o_cnt    = r_cnt;

    // The append guard (cnt<=16 before append) keeps the window from overfilling
    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n) r_cnt <= CNT_W'(WIN_W));

endmodule

// File: rtl/egd_bitstream_ctrl.sv
// Sequences one Exp-Golomb syntax element at a time over a 32-bit bit window.
// Latency: cmd accepted with >=16 bits buffered -> res_valid three cycles later.
// Backpressure: one command in flight; result held until res_ready; ERR blocks all input.
module egd_bitstream_ctrl
    import egd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              soft_clr,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_word,
    output logic              bs_ready,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_sel,
    output logic              cmd_ready,
    output logic [WORD_W-1:0] dec_window,
    output logic [1:0]        dec_sel,
    input  logic [LEN_W-1:0]  dec_len,
    input  logic [VAL_W-1:0]  dec_value,
    output logic              res_valid,
    output logic [VAL_W-1:0]  res_value,
    output logic [1:0]        res_sel,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  bits_avail,
    output logic              err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_dec_sel;
    logic [VAL_W-1:0] r_res_value;
    logic [1:0]       r_res_sel;
    logic             r_err;

    logic             w_len_ok;
    logic             w_cmd_acc;
    logic             w_consume;
    logic             w_set_err;
    logic             w_in_err;
    logic [CNT_W-1:0] w_cnt;

    assign w_len_ok = len_legal(dec_len);

    egd_bit_window u_window (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (soft_clr),
        .i_consume  (w_consume),
        .i_len      (dec_len),
        .i_hold     (w_in_err),
        .i_bs_valid (bs_valid),
        .i_bs_word  (bs_word),
        .o_bs_ready (bs_ready),
        .o_window   (dec_window),
        .o_cnt      (w_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs; soft_clr overrides every transition
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        res_valid    = 1'b0;
        w_in_err     = 1'b0;
        w_cmd_acc    = 1'b0;
        w_consume    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                w_cmd_acc = cmd_valid && !soft_clr;
                if (cmd_valid) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (w_cnt >= CNT_W'(WORD_W)) begin
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                if (w_len_ok) begin
                    w_consume    = !soft_clr;
                    w_state_next = OUTPUT;
                end else begin
                    w_set_err    = !soft_clr;
                    w_state_next = ERR;
                end
            end
            OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            ERR: begin
                w_in_err = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (soft_clr) begin
            w_state_next = IDLE;
        end
    end

    // Command select latch, captured on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dec_sel <= SEL_UE;
        end else if (w_cmd_acc) begin
            r_dec_sel <= cmd_sel;
        end
    end

    // Result register, loaded on a legal decode and held through OUTPUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_value <= '0;
            r_res_sel   <= SEL_UE;
        end else if (w_consume) begin
            r_res_value <= dec_value;
            r_res_sel   <= r_dec_sel;
        end
    end

    // Sticky illegal-length flag, cleared only by flush or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (soft_clr) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end
    end

    assign dec_sel    = r_dec_sel;
    assign res_value  = r_res_value;
    assign res_sel    = r_res_sel;
    assign err        = r_err;
    assign bits_avail = w_cnt;

endmodule

// File: tb/tb_egd_bitstream_ctrl.sv
// Directed bench for egd_bitstream_ctrl; the decoder is modelled by driving dec_len/dec_value.
// Latency: n/a.
// Backpressure: n/a.
module tb_egd_bitstream_ctrl;
    import egd_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              soft_clr;
    logic              bs_valid;
    logic [WORD_W-1:0] bs_word;
    logic              bs_ready;
    logic              cmd_valid;
    logic [1:0]        cmd_sel;
    logic              cmd_ready;
    logic [WORD_W-1:0] dec_window;
    logic [1:0]        dec_sel;
    logic [LEN_W-1:0]  dec_len;
    logic [VAL_W-1:0]  dec_value;
    logic              res_valid;
    logic [VAL_W-1:0]  res_value;
    logic [1:0]        res_sel;
    logic              res_ready;
    logic [CNT_W-1:0]  bits_avail;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    egd_bitstream_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soft_clr   (soft_clr),
        .bs_valid   (bs_valid),
        .bs_word    (bs_word),
        .bs_ready   (bs_ready),
        .cmd_valid  (cmd_valid),
        .cmd_sel    (cmd_sel),
        .cmd_ready  (cmd_ready),
        .dec_window (dec_window),
        .dec_sel    (dec_sel),
        .dec_len    (dec_len),
        .dec_value  (dec_value),
        .res_valid  (res_valid),
        .res_value  (res_value),
        .res_sel    (res_sel),
        .res_ready  (res_ready),
        .bits_avail (bits_avail),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        soft_clr  = 1'b0;
        bs_valid  = 1'b0;
        bs_word   = '0;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        dec_len   = '0;
        dec_value = '0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_bits", 32'(bits_avail), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_bs_ready", 32'(bs_ready), 32'h1);
        chk("rst_window", 32'(dec_window), 32'h0);
        chk("rst_dec_sel", 32'(dec_sel), 32'h0);
        reset_n = 1'b1;

        // Two words, then a 3-bit codeword
        bs_valid = 1'b1; bs_word = 16'hA5A5;
        tick();
        bs_word = 16'h1234;
        tick();
        bs_valid = 1'b0;
        chk("t2_bits32", 32'(bits_avail), 32'd32);
        chk("t2_bs_ready_full", 32'(bs_ready), 32'h0);
        chk("t2_window_pre", 32'(dec_window), 32'hA5A5);
        cmd_valid = 1'b1; cmd_sel = 2'd0; dec_len = 5'd3; dec_value = 8'h07;
        tick();
        cmd_valid = 1'b0;
        chk("t2_fill_cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        chk("t2_decode_window", 32'(dec_window), 32'hA5A5);
        chk("t2_decode_no_res", 32'(res_valid), 32'h0);
        tick();
        chk("t2_res_valid", 32'(res_valid), 32'h1);
        chk("t2_res_value", 32'(res_value), 32'h07);
        chk("t2_res_sel", 32'(res_sel), 32'h0);
        chk("t2_bits29", 32'(bits_avail), 32'd29);
        chk("t2_window_post", 32'(dec_window), 32'h2D28);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t2_res_taken", 32'(res_valid), 32'h0);
        chk("t2_back_idle", 32'(cmd_ready), 32'h1);

        // Flush, then flush again with competing handshakes that must be dropped
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        chk("clr_bits", 32'(bits_avail), 32'h0);
        chk("clr_window", 32'(dec_window), 32'h0);
        soft_clr = 1'b1; bs_valid = 1'b1; bs_word = 16'hBEEF; cmd_valid = 1'b1; cmd_sel = 2'd2;
        #1;
        chk("clr_bs_ready_gated", 32'(bs_ready), 32'h0);
        tick();
        soft_clr = 1'b0; bs_valid = 1'b0; cmd_valid = 1'b0;
        chk("clr_drop_word", 32'(bits_avail), 32'h0);
        chk("clr_drop_cmd", 32'(cmd_ready), 32'h1);

        // Command before data: FILL waits; max legal length 16
        cmd_valid = 1'b1; cmd_sel = 2'd1; dec_len = 5'd16; dec_value = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("t3_fill_hold_res", 32'(res_valid), 32'h0);
        chk("t3_fill_hold_cmd", 32'(cmd_ready), 32'h0);
        chk("t3_fill_hold_bits", 32'(bits_avail), 32'h0);
        bs_valid = 1'b1; bs_word = 16'hFFFF;
        tick();
        bs_valid = 1'b0;
        chk("t3_bits16", 32'(bits_avail), 32'd16);
        chk("t3_window", 32'(dec_window), 32'hFFFF);
        chk("t3_dec_sel", 32'(dec_sel), 32'h1);
        tick();
        chk("t3_decode_no_res", 32'(res_valid), 32'h0);
        tick();
        chk("t3_res_valid", 32'(res_valid), 32'h1);
        chk("t3_res_value", 32'(res_value), 32'h5A);
        chk("t3_res_sel", 32'(res_sel), 32'h1);
        chk("t3_bits0", 32'(bits_avail), 32'h0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Consume 5 and append 0x8001 in the same DECODE cycle
        bs_valid = 1'b1; bs_word = 16'hF0F0;
        tick();
        bs_valid = 1'b0;
        cmd_valid = 1'b1; cmd_sel = 2'd3; dec_len = 5'd5; dec_value = 8'h33;
        tick();
        cmd_valid = 1'b0;
        tick();
        bs_valid = 1'b1; bs_word = 16'h8001;
        #1;
        chk("t4_bs_ready_decode", 32'(bs_ready), 32'h1);
        tick();
        bs_valid = 1'b0;
        chk("t4_bits27", 32'(bits_avail), 32'd27);
        chk("t4_window", 32'(dec_window), 32'h1E10);
        chk("t4_res_value", 32'(res_value), 32'h33);
        chk("t4_res_sel", 32'(res_sel), 32'h3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        // Drop the 11 leftover bits so the appended word reaches the top
        cmd_valid = 1'b1; cmd_sel = 2'd0; dec_len = 5'd11; dec_value = 8'h44;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t4_word_at_20_5", 32'(dec_window), 32'h8001);
        chk("t4_bits16", 32'(bits_avail), 32'd16);
        chk("t4_res_value2", 32'(res_value), 32'h44);

        // Result stalled for 4 cycles while upstream keeps offering
        bs_valid = 1'b1; bs_word = 16'h00FF; cmd_valid = 1'b1; cmd_sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_res_valid", 32'(res_valid), 32'h1);
            chk("t6_res_value", 32'(res_value), 32'h44);
            chk("t6_res_sel", 32'(res_sel), 32'h0);
            chk("t6_cmd_ready", 32'(cmd_ready), 32'h0);
            chk("t6_window", 32'(dec_window), 32'h8001);
            chk("t6_bits32", 32'(bits_avail), 32'd32);
        end
        chk("t6_dec_sel_held", 32'(dec_sel), 32'h0);
        bs_valid = 1'b0; cmd_valid = 1'b0;

        // Asynchronous reset while OUTPUT is holding a result
        reset_n = 1'b0;
        #1;
        chk("t1_res_valid", 32'(res_valid), 32'h0);
        chk("t1_err", 32'(err), 32'h0);
        chk("t1_bits", 32'(bits_avail), 32'h0);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("t1_bs_ready", 32'(bs_ready), 32'h1);
        chk("t1_res_value", 32'(res_value), 32'h0);
        tick();
        reset_n = 1'b1;

        // Zero-length codeword locks into ERR until flushed
        bs_valid = 1'b1; bs_word = 16'h1111;
        tick();
        bs_valid = 1'b0;
        cmd_valid = 1'b1; cmd_sel = 2'd2; dec_len = 5'd0; dec_value = 8'h99;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t5_err", 32'(err), 32'h1);
        chk("t5_no_res", 32'(res_valid), 32'h0);
        bs_valid = 1'b1; bs_word = 16'h2222; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_err_held", 32'(err), 32'h1);
            chk("t5_bs_ready", 32'(bs_ready), 32'h0);
            chk("t5_cmd_ready", 32'(cmd_ready), 32'h0);
            chk("t5_res_valid", 32'(res_valid), 32'h0);
        end
        bs_valid = 1'b0; cmd_valid = 1'b0;
        chk("t5_bits_unchanged", 32'(bits_avail), 32'd16);
        chk("t5_window_unchanged", 32'(dec_window), 32'h1111);
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        #1;
        chk("t5_clr_err", 32'(err), 32'h0);
        chk("t5_clr_bits", 32'(bits_avail), 32'h0);
        chk("t5_clr_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("t5_clr_bs_ready", 32'(bs_ready), 32'h1);

        // Length 17 is one past the decoder window and also illegal
        bs_valid = 1'b1; bs_word = 16'hABCD;
        tick();
        bs_valid = 1'b0;
        cmd_valid = 1'b1; cmd_sel = 2'd1; dec_len = 5'd17; dec_value = 8'h01;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("len17_err", 32'(err), 32'h1);
        chk("len17_bits", 32'(bits_avail), 32'd16);
        chk("len17_window", 32'(dec_window), 32'hABCD);
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        chk("len17_clr", 32'(err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
